// File: rtl/learn_costs_param_if.sv
// Request, result-flag and shared-memory bus of the routing-table update engine.
`timescale 1ns/1ps
interface learn_costs_param_if #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  start;
  logic [WORD_WIDTH-1:0] fsource_id;
  logic [WORD_WIDTH-1:0] fbattery_stat;
  logic [WORD_WIDTH-1:0] fvalue;
  logic [WORD_WIDTH-1:0] fcluster_id;
  logic [WORD_WIDTH-1:0] data_in;
  logic [ADDR_WIDTH-1:0] address;
  logic                  wr_en;
  logic [WORD_WIDTH-1:0] data_out;
  logic                  busy;
  logic                  done;
  logic                  reinit;
  logic                  new_neighbor;
  logic                  table_full;

  modport master (
    output start, fsource_id, fbattery_stat, fvalue, fcluster_id, data_in,
    input  address, wr_en, data_out, busy, done, reinit, new_neighbor, table_full
  );

  modport slave (
    input  start, fsource_id, fbattery_stat, fvalue, fcluster_id, data_in,
    output address, wr_en, data_out, busy, done, reinit, new_neighbor, table_full
  );
endinterface

// File: rtl/learn_costs_param.sv
// Q-learning routing node: folds one feedback packet into the neighbor table held
// in shared data memory (update on hit, append on miss, then copy the known-sink list).
`timescale 1ns/1ps
module learn_costs_param #(
  parameter int unsigned           WORD_WIDTH    = 16,
  parameter int unsigned           ADDR_WIDTH    = 16,
  parameter int unsigned           MAX_NEIGHBORS = 64,
  parameter int unsigned           MAX_SINKS     = 8,
  parameter int unsigned           RD_LATENCY    = 1,
  parameter logic [ADDR_WIDTH-1:0] NCNT_ADDR     = 16'h068A,
  parameter logic [ADDR_WIDTH-1:0] SCNT_ADDR     = 16'h0688,
  parameter logic [ADDR_WIDTH-1:0] SINK_BASE     = 16'h0008,
  parameter logic [ADDR_WIDTH-1:0] NID_BASE      = 16'h0048,
  parameter logic [ADDR_WIDTH-1:0] CLUS_BASE     = 16'h00C8,
  parameter logic [ADDR_WIDTH-1:0] BATT_BASE     = 16'h0148,
  parameter logic [ADDR_WIDTH-1:0] Q_BASE        = 16'h01C8,
  parameter logic [ADDR_WIDTH-1:0] SINKID_BASE   = 16'h0248,
  parameter int unsigned           SINKID_STRIDE = 16
) (
  input logic              clock,
  input logic              nreset,
  learn_costs_param_if.slave bus
);

  localparam int unsigned IDX_W    = $clog2(MAX_NEIGHBORS + 1);
  localparam int unsigned K_W      = $clog2(MAX_SINKS + 1);
  localparam logic [1:0]  LAT_LAST = 2'(RD_LATENCY - 1);

  if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_bad_latency
    $error("learn_costs_param: RD_LATENCY must be 1..3");
  end

  typedef enum logic [4:0] {
    IDLE, RD_NCNT, RD_SCNT, SRCH_RD, SRCH_CMP,
    HIT_BATT, HIT_CLUS, HIT_QRD, HIT_QWR,
    APP_NID, APP_BATT, APP_Q, APP_CLUS,
    SINK_RD, SINK_WR, NCNT_WR, DONE
  } state_t;

  state_t                state;
  logic [1:0]            lat;
  logic [IDX_W-1:0]      n_cnt;
  logic [K_W-1:0]        s_cnt;
  logic [IDX_W-1:0]      n_idx;
  logic [K_W-1:0]        k_idx;
  logic                  appending;
  logic [WORD_WIDTH-1:0] src_id;
  logic [WORD_WIDTH-1:0] batt_val;
  logic [WORD_WIDTH-1:0] q_val;
  logic [WORD_WIDTH-1:0] clus_val;
  logic [WORD_WIDTH-1:0] cmp_word;
  logic [ADDR_WIDTH-1:0] address_q;
  logic [WORD_WIDTH-1:0] data_out_q;
  logic                  wr_en_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  reinit_q;
  logic                  new_q;
  logic                  full_q;
  logic                  rd_ready;

  assign rd_ready         = (lat == LAT_LAST);
  assign bus.address      = address_q;
  assign bus.data_out     = data_out_q;
  assign bus.wr_en        = wr_en_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.reinit       = reinit_q;
  assign bus.new_neighbor = new_q;
  assign bus.table_full   = full_q;

  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH-1:0] base,
                                                      input logic [ADDR_WIDTH-1:0] idx);
    return base + (idx << 1);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] sink_addr(input logic [IDX_W-1:0] n,
                                                      input logic [K_W-1:0]   k);
    return SINKID_BASE + ADDR_WIDTH'(n) * ADDR_WIDTH'(SINKID_STRIDE) + (ADDR_WIDTH'(k) << 1);
  endfunction

  function automatic logic [IDX_W-1:0] clamp_n(input logic [WORD_WIDTH-1:0] w);
    return (w >= WORD_WIDTH'(MAX_NEIGHBORS)) ? IDX_W'(MAX_NEIGHBORS) : IDX_W'(w);
  endfunction

  function automatic logic [K_W-1:0] clamp_s(input logic [WORD_WIDTH-1:0] w);
    return (w >= WORD_WIDTH'(MAX_SINKS)) ? K_W'(MAX_SINKS) : K_W'(w);
  endfunction

  // Outputs are registered: each transition loads the address/data/strobe the next
  // state presents, so a write is visible for exactly the one cycle of its state.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      state      <= IDLE;
      lat        <= '0;
      n_cnt      <= '0;
      s_cnt      <= '0;
      n_idx      <= '0;
      k_idx      <= '0;
      appending  <= 1'b0;
      src_id     <= '0;
      batt_val   <= '0;
      q_val      <= '0;
      clus_val   <= '0;
      cmp_word   <= '0;
      address_q  <= '0;
      data_out_q <= '0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      reinit_q   <= 1'b0;
      new_q      <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            src_id    <= bus.fsource_id;
            batt_val  <= bus.fbattery_stat;
            q_val     <= bus.fvalue;
            clus_val  <= bus.fcluster_id;
            reinit_q  <= 1'b0;
            new_q     <= 1'b0;
            full_q    <= 1'b0;
            appending <= 1'b0;
            busy_q    <= 1'b1;
            lat       <= '0;
            address_q <= NCNT_ADDR;
            state     <= RD_NCNT;
          end
        end
        RD_NCNT: begin
          if (rd_ready) begin
            lat       <= '0;
            n_cnt     <= clamp_n(bus.data_in);
            address_q <= SCNT_ADDR;
            state     <= RD_SCNT;
          end else begin
            lat <= lat + 2'd1;
          end
        end
        RD_SCNT: begin
          if (rd_ready) begin
            lat       <= '0;
            s_cnt     <= clamp_s(bus.data_in);
            n_idx     <= '0;
            address_q <= NID_BASE;
            state     <= SRCH_RD;
          end else begin
            lat <= lat + 2'd1;
          end
        end
        // The miss decision is taken here without a cycle of its own.
        SRCH_RD: begin
          if (n_idx == n_cnt) begin
            if (n_cnt >= IDX_W'(MAX_NEIGHBORS)) begin
              full_q <= 1'b1;
              done_q <= 1'b1;
              busy_q <= 1'b0;
              state  <= DONE;
            end else begin
              appending  <= 1'b1;
              address_q  <= word_addr(NID_BASE, ADDR_WIDTH'(n_idx));
              data_out_q <= src_id;
              wr_en_q    <= 1'b1;
              state      <= APP_NID;
            end
          end else if (rd_ready) begin
            lat      <= '0;
            cmp_word <= bus.data_in;
            state    <= SRCH_CMP;
          end else begin
            lat <= lat + 2'd1;
          end
        end
        SRCH_CMP: begin
          if (cmp_word == src_id) begin
            address_q  <= word_addr(BATT_BASE, ADDR_WIDTH'(n_idx));
            data_out_q <= batt_val;
            wr_en_q    <= 1'b1;
            state      <= HIT_BATT;
          end else begin
            n_idx     <= IDX_W'(n_idx + 1'b1);
            address_q <= word_addr(NID_BASE, ADDR_WIDTH'(IDX_W'(n_idx + 1'b1)));
            state     <= SRCH_RD;
          end
        end
        HIT_BATT: begin
          address_q  <= word_addr(CLUS_BASE, ADDR_WIDTH'(n_idx));
          data_out_q <= clus_val;
          wr_en_q    <= 1'b1;
          state      <= HIT_CLUS;
        end
        HIT_CLUS: begin
          address_q <= word_addr(Q_BASE, ADDR_WIDTH'(n_idx));
          state     <= HIT_QRD;
        end
        HIT_QRD: begin
          if (rd_ready) begin
            lat        <= '0;
            reinit_q   <= (bus.data_in < q_val);
            data_out_q <= q_val;
            wr_en_q    <= 1'b1;
            state      <= HIT_QWR;
          end else begin
            lat <= lat + 2'd1;
          end
        end
        HIT_QWR: begin
          k_idx     <= '0;
          address_q <= SINK_BASE;
          state     <= SINK_RD;
        end
        APP_NID: begin
          address_q  <= word_addr(BATT_BASE, ADDR_WIDTH'(n_idx));
          data_out_q <= batt_val;
          wr_en_q    <= 1'b1;
          state      <= APP_BATT;
        end
        APP_BATT: begin
          address_q  <= word_addr(Q_BASE, ADDR_WIDTH'(n_idx));
          data_out_q <= q_val;
          wr_en_q    <= 1'b1;
          state      <= APP_Q;
        end
        APP_Q: begin
          address_q  <= word_addr(CLUS_BASE, ADDR_WIDTH'(n_idx));
          data_out_q <= clus_val;
          wr_en_q    <= 1'b1;
          state      <= APP_CLUS;
        end
        APP_CLUS: begin
          k_idx     <= '0;
          address_q <= SINK_BASE;
          state     <= SINK_RD;
        end
        SINK_RD: begin
          if (k_idx == s_cnt) begin
            if (appending) begin
              address_q  <= NCNT_ADDR;
              data_out_q <= WORD_WIDTH'(n_cnt) + 1'b1;
              wr_en_q    <= 1'b1;
              state      <= NCNT_WR;
            end else begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
              state  <= DONE;
            end
          end else if (rd_ready) begin
            lat        <= '0;
            address_q  <= sink_addr(n_idx, k_idx);
            data_out_q <= bus.data_in;
            wr_en_q    <= 1'b1;
            state      <= SINK_WR;
          end else begin
            lat <= lat + 2'd1;
          end
        end
        SINK_WR: begin
          k_idx     <= K_W'(k_idx + 1'b1);
          address_q <= word_addr(SINK_BASE, ADDR_WIDTH'(K_W'(k_idx + 1'b1)));
          state     <= SINK_RD;
        end
        NCNT_WR: begin
          new_q  <= 1'b1;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_learn_costs_param.sv
// Scoreboard bench for learn_costs_param: two engines (read latency 1 and 3) on
// word-addressed memory models; expected writes queued at stimulus, popped on wr_en.
`timescale 1ns/1ps
module tb_learn_costs_param;

  localparam logic [15:0] NCNT    = 16'h068A;
  localparam logic [15:0] SCNT    = 16'h0688;
  localparam logic [15:0] SINK    = 16'h0008;
  localparam logic [15:0] NID     = 16'h0048;
  localparam logic [15:0] CLUS    = 16'h00C8;
  localparam logic [15:0] BATT    = 16'h0148;
  localparam logic [15:0] QV      = 16'h01C8;
  localparam logic [15:0] SINKID  = 16'h0248;

  logic clock  = 1'b0;
  logic nreset = 1'b0;
  always #5 clock = ~clock;

  learn_costs_param_if #(.WORD_WIDTH(16), .ADDR_WIDTH(16)) b1 ();
  learn_costs_param_if #(.WORD_WIDTH(16), .ADDR_WIDTH(16)) b3 ();

  learn_costs_param #(.RD_LATENCY(1)) u1 (.clock(clock), .nreset(nreset), .bus(b1));
  learn_costs_param #(.RD_LATENCY(3)) u3 (.clock(clock), .nreset(nreset), .bus(b3));

  logic [15:0] mem1 [0:1023];
  logic [15:0] mem3 [0:1023];
  logic [15:0] prev3 = '0;
  int          age3  = 0;

  // Latency-3 model returns junk until the address has been held long enough.
  always @(posedge clock) begin
    if (b1.wr_en) mem1[b1.address[10:1]] <= b1.data_out;
    if (b3.wr_en) mem3[b3.address[10:1]] <= b3.data_out;
    if (b3.address == prev3) begin
      if (age3 < 7) age3 <= age3 + 1;
    end else begin
      age3 <= 1;
    end
    prev3 <= b3.address;
  end

  assign b1.data_in = mem1[b1.address[10:1]];
  assign b3.data_in = (b3.address == prev3 && age3 >= 2) ? mem3[b3.address[10:1]] : 16'hBAD0;

  typedef struct { logic [15:0] a; logic [15:0] d; } wr_t;
  wr_t sb [$];

  typedef struct packed {
    logic [15:0] address;
    logic wr_en, busy, done, reinit, nn, full;
  } obs_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic observe_write(input logic we, input logic [15:0] a, input logic [15:0] d);
    wr_t e;
    if (sb.size() == 0) begin
      check("unexpected_wr_en", 32'(we), 32'(0));
    end else begin
      e = sb.pop_front();
      check("wr_addr", 32'(a), 32'(e.a));
      check("wr_data", 32'(d), 32'(e.d));
    end
  endtask

  always @(negedge clock) begin
    if (b1.wr_en) observe_write(b1.wr_en, b1.address, b1.data_out);
    if (b3.wr_en) observe_write(b3.wr_en, b3.address, b3.data_out);
  end

  function automatic obs_t sample(input int sel);
    obs_t o;
    if (sel == 0) o = '{b1.address, b1.wr_en, b1.busy, b1.done, b1.reinit, b1.new_neighbor, b1.table_full};
    else          o = '{b3.address, b3.wr_en, b3.busy, b3.done, b3.reinit, b3.new_neighbor, b3.table_full};
    return o;
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) b1.start = v;
    else          b3.start = v;
  endtask

  task automatic drive(input logic [15:0] id, batt, fv, clus);
    b1.fsource_id = id; b1.fbattery_stat = batt; b1.fvalue = fv; b1.fcluster_id = clus;
    b3.fsource_id = id; b3.fbattery_stat = batt; b3.fvalue = fv; b3.fcluster_id = clus;
  endtask

  task automatic put_word(input logic [15:0] a, input logic [15:0] v);
    mem1[a[10:1]] = v;
    mem3[a[10:1]] = v;
  endtask

  // Neighbor IDs {5, 9, 102, 103, ...}, qValue[1] = 10, knownSinks[k] = 3 + 4k.
  task automatic init_mem(input int ncnt, input int scnt);
    for (int i = 0; i < 1024; i++) begin
      mem1[i] = '0;
      mem3[i] = '0;
    end
    put_word(NCNT, 16'(ncnt));
    put_word(SCNT, 16'(scnt));
    for (int k = 0; k < 16; k++) put_word(16'(SINK + 2 * k), 16'(3 + 4 * k));
    for (int j = 0; j < 64; j++)
      put_word(16'(NID + 2 * j), (j == 0) ? 16'd5 : (j == 1) ? 16'd9 : 16'(100 + j));
    put_word(16'(QV + 2), 16'd10);
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    sb.push_back(e);
  endtask

  task automatic push_sinks(input int n, input int s);
    for (int k = 0; k < s; k++) push(16'(SINKID + 16 * n + 2 * k), 16'(3 + 4 * k));
  endtask

  task automatic push_hit(input int n, input logic [15:0] batt, clus, fv, input int s);
    push(16'(BATT + 2 * n), batt);
    push(16'(CLUS + 2 * n), clus);
    push(16'(QV + 2 * n), fv);
    push_sinks(n, s);
  endtask

  task automatic push_append(input int n, input logic [15:0] id, batt, clus, fv, input int s);
    push(16'(NID + 2 * n), id);
    push(16'(BATT + 2 * n), batt);
    push(16'(QV + 2 * n), fv);
    push(16'(CLUS + 2 * n), clus);
    push_sinks(n, s);
    push(NCNT, 16'(n + 1));
  endtask

  task automatic run_op(input int sel, input logic [15:0] id, batt, fv, clus,
                        input logic er, en, ef, input int exp_lat, input bit poke);
    int   cyc;
    logic seen;
    obs_t o;
    @(negedge clock);
    drive(id, batt, fv, clus);
    set_start(sel, 1'b1);
    @(negedge clock);
    set_start(sel, 1'b0);
    o = sample(sel);
    check("busy_after_start", 32'(o.busy), 32'(1));
    cyc = 0;
    while (!o.done && cyc < 400) begin
      set_start(sel, poke && cyc == 3);
      @(negedge clock);
      cyc++;
      o = sample(sel);
    end
    set_start(sel, 1'b0);
    check("done_pulse", 32'(o.done), 32'(1));
    if (exp_lat >= 0) check("latency", 32'(cyc), 32'(exp_lat));
    check("busy_at_done", 32'(o.busy), 32'(0));
    check("reinit", 32'(o.reinit), 32'(er));
    check("new_neighbor", 32'(o.nn), 32'(en));
    check("table_full", 32'(o.full), 32'(ef));
    if (poke) set_start(sel, 1'b1);
    @(negedge clock);
    set_start(sel, 1'b0);
    o = sample(sel);
    check("done_one_cycle", 32'(o.done), 32'(0));
    check("flags_held", 32'({o.reinit, o.nn, o.full}), 32'({er, en, ef}));
    if (poke) begin
      seen = 1'b0;
      repeat (6) begin
        @(negedge clock);
        o = sample(sel);
        seen = seen | o.busy | o.done;
      end
      check("no_restart", 32'(seen), 32'(0));
    end
    check("sb_empty", 32'(sb.size()), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    logic seen;
    int   t;
    b1.start = 1'b0;
    b3.start = 1'b0;
    drive('0, '0, '0, '0);
    init_mem(0, 0);
    repeat (3) @(negedge clock);
    o = sample(0);
    check("rst_address", 32'(o.address), 32'(0));
    check("rst_outputs", 32'({o.wr_en, o.busy, o.done, o.reinit, o.nn, o.full}), 32'(0));
    o = sample(1);
    check("rst_outputs_l3", 32'({o.wr_en, o.busy, o.done, o.reinit, o.nn, o.full}), 32'(0));
    nreset = 1'b1;

    // hit at index 1, stored 10 < 20
    init_mem(2, 2);
    push_hit(1, 16'd80, 16'd4, 16'd20, 2);
    run_op(0, 16'd9, 16'd80, 16'd20, 16'd4, 1'b1, 1'b0, 1'b0, 15, 1'b0);

    // hit, stored 10 > 5; stray starts while busy and on done are ignored
    init_mem(2, 2);
    push_hit(1, 16'd81, 16'd4, 16'd5, 2);
    run_op(0, 16'd9, 16'd81, 16'd5, 16'd4, 1'b0, 1'b0, 1'b0, 15, 1'b1);
    check("q1_mem", 32'(mem1[9'h0E5]), 32'(5));

    // equal Q value is not an improvement
    init_mem(2, 2);
    push_hit(1, 16'd1, 16'd2, 16'd10, 2);
    run_op(0, 16'd9, 16'd1, 16'd10, 16'd2, 1'b0, 1'b0, 1'b0, 15, 1'b0);

    // append at index 2
    init_mem(2, 2);
    push_append(2, 16'd12, 16'd50, 16'd6, 16'd30, 2);
    run_op(0, 16'd12, 16'd50, 16'd30, 16'd6, 1'b0, 1'b1, 1'b0, -1, 1'b0);

    // full table, and an over-range count clamped to full
    init_mem(64, 2);
    run_op(0, 16'd999, 16'd1, 16'd2, 16'd3, 1'b0, 1'b0, 1'b1, 131, 1'b0);
    init_mem(100, 2);
    run_op(0, 16'd999, 16'd1, 16'd2, 16'd3, 1'b0, 1'b0, 1'b1, 131, 1'b0);

    // empty table, no sinks
    init_mem(0, 0);
    push_append(0, 16'd42, 16'd7, 16'd8, 16'd9, 0);
    run_op(0, 16'd42, 16'd7, 16'd9, 16'd8, 1'b0, 1'b1, 1'b0, -1, 1'b0);

    // sink count 20 clamps to 8; hit at index 0 with stored 0
    init_mem(2, 20);
    push_hit(0, 16'd11, 16'd12, 16'd13, 8);
    run_op(0, 16'd5, 16'd11, 16'd13, 16'd12, 1'b1, 1'b0, 1'b0, 25, 1'b0);

    // read latency 3 repeats the first scenario
    init_mem(2, 2);
    push_hit(1, 16'd80, 16'd4, 16'd20, 2);
    run_op(1, 16'd9, 16'd80, 16'd20, 16'd4, 1'b1, 1'b0, 1'b0, -1, 1'b0);

    // reset in the middle of the sink copy
    init_mem(2, 2);
    push(16'(BATT + 2), 16'd80);
    push(16'(CLUS + 2), 16'd4);
    push(16'(QV + 2), 16'd20);
    push(16'(SINKID + 16), 16'd3);
    @(negedge clock);
    drive(16'd9, 16'd80, 16'd20, 16'd4);
    set_start(0, 1'b1);
    @(negedge clock);
    set_start(0, 1'b0);
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clock);
      t++;
    end
    check("writes_before_reset", 32'(sb.size()), 32'(0));
    @(negedge clock);
    nreset = 1'b0;
    @(negedge clock);
    o = sample(0);
    check("abort_address", 32'(o.address), 32'(0));
    check("abort_outputs", 32'({o.wr_en, o.busy, o.done, o.reinit, o.nn, o.full}), 32'(0));
    nreset = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clock);
      o = sample(0);
      seen = seen | o.busy | o.done | o.wr_en;
    end
    check("idle_after_abort", 32'(seen), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
